fetch_unit: RTL and testbench

Instruction fetch stage for the sequential RISC-V core. Sits between the instruction memory and the decode/execute logic: it generates sequential fetch addresses, issues pipelined requests to instruction memory, buffers returned words in a small prefetch queue, and presents them to decode with a valid/ready handshake. It handles control-flow redirects from the branch/jump logic. It also detects the all-zero program-end word.

---
 rtl/fetch_unit.sv | 270 +++++++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage for the sequential RISC-V core. Generates
// sequential word-aligned fetch addresses and issues pipelined requests to
// instruction memory. Returned words are buffered in a small prefetch queue
// and presented to decode with a valid/ready handshake. Handles taken
// branch/jump redirects, and stops fetching once the all-zero program-end
// word is enqueued.
//
// Parameters
//   DEPTH     prefetch queue entries (power of two, 2..16). This is also the
//             cap on buffered plus outstanding words.
//   RESET_PC  first fetch address after reset.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-low reset (0 = reset)
//   imem_req_valid  fetch request to instruction memory
//   imem_req_addr   word-aligned byte address of the request
//   imem_req_ready  memory accepts the request this cycle
//   imem_rsp_valid  returned word (in order, >= 1 cycle after acceptance)
//   imem_rsp_data   returned instruction word
//   instr_valid     head of the prefetch queue is valid
//   instr           head instruction (holds its last value while invalid)
//   instr_pc        address of the head instruction
//   instr_ready     decode consumes the head this cycle
//   redirect_valid  taken branch/jump, one-cycle pulse
//   redirect_pc     redirect target, bits [1:0] ignored
//   halted          the all-zero word has been consumed by decode
//
// Optional feature macro: FETCH_STATS_EN
//   When defined, adds saturating 32-bit counters on three extra outputs:
//   stat_fetched (accepted requests), stat_dropped (responses not enqueued)
//   and stat_stall (cycles with instr_valid=0 while not halted).
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_dropped,
  output logic [31:0] stat_stall
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [31:0]   pc_q,        pc_d;
  logic          run_q;
  logic [CW-1:0] count_q,     count_d;
  logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [CW-1:0] outst_q,     outst_d;
  logic [CW-1:0] drop_q,      drop_d;
  logic [AW-1:0] infl_rd_q,   infl_rd_d;
  logic [AW-1:0] infl_wr_q,   infl_wr_d;
  logic          stop_q,      stop_d;
  logic          halted_q,    halted_d;
  logic          iv_q,        iv_d;
  logic [31:0]   instr_q,     instr_d;
  logic [31:0]   instr_pc_q,  instr_pc_d;

  // Prefetch queue storage and the in-flight request address FIFO.
  logic [31:0]   q_data_q  [DEPTH];
  logic [31:0]   q_pc_q    [DEPTH];
  logic [31:0]   infl_pc_q [DEPTH];

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic [CW:0] credit_used;
  logic        accept;
  logic        push;
  logic        pop;
  logic        rsp_lost;
  logic [31:0] rsp_pc;

  // Every buffered word and every outstanding request holds a credit, so a
  // returning response always has a queue slot waiting for it.
  assign credit_used = {1'b0, count_q} + {1'b0, outst_q};

  // The redirect and reset gating is combinational so that no request can be
  // accepted in a redirect cycle or while reset is held low.
  assign imem_req_valid = reset & run_q & ~halted_q & ~stop_q & ~redirect_valid
                        & (credit_used < DEPTH_W);
  assign imem_req_addr  = pc_q;

  assign accept   = imem_req_valid & imem_req_ready;
  assign push     = imem_rsp_valid & (drop_q == '0) & ~stop_q & ~redirect_valid;
  assign pop      = iv_q & instr_ready & ~redirect_valid;
  assign rsp_lost = imem_rsp_valid & ~push;
  assign rsp_pc   = infl_pc_q[infl_rd_q];

  assign instr_valid = iv_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign halted      = halted_q;

  // Low target bits are forced to zero and never looked at.
  logic unused_ok;
  assign unused_ok = &{1'b0, redirect_pc[1:0]};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    outst_d    = outst_q + CW'(accept) - CW'(imem_rsp_valid);
    drop_d     = drop_q;
    infl_wr_d  = infl_wr_q + AW'(accept);
    infl_rd_d  = infl_rd_q + AW'(imem_rsp_valid);
    stop_d     = stop_q;
    halted_d   = halted_q;
    iv_d       = iv_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    if (redirect_valid) begin
      // Everything still in flight belongs to the abandoned path, including
      // requests whose responses have not yet come back.
      pc_d     = {redirect_pc[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
      drop_d   = outst_d;
      stop_d   = 1'b0;
      halted_d = 1'b0;
      iv_d     = 1'b0;
    end else begin
      if (accept) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push && (imem_rsp_data == 32'd0)) begin
        stop_d = 1'b1;
      end
      if (pop && (instr_q == 32'd0)) begin
        halted_d = 1'b1;
      end

      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      iv_d     = (count_d != '0);

      // The head output registers track the next head entry. When the queue
      // drains to empty before this cycle's push, the arriving word becomes
      // the head directly; when it drains completely, the last head is held.
      if (count_d != '0) begin
        if (count_q == CW'(pop)) begin
          instr_d    = imem_rsp_data;
          instr_pc_d = rsp_pc;
        end else begin
          instr_d    = q_data_q[rd_ptr_d];
          instr_pc_d = q_pc_q[rd_ptr_d];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      run_q      <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      infl_rd_q  <= '0;
      infl_wr_q  <= '0;
      stop_q     <= 1'b0;
      halted_q   <= 1'b0;
      iv_q       <= 1'b0;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      run_q      <= 1'b1;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      infl_rd_q  <= infl_rd_d;
      infl_wr_q  <= infl_wr_d;
      stop_q     <= stop_d;
      halted_q   <= halted_d;
      iv_q       <= iv_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // -------------------------------------------------------------------------
  // Storage arrays (no reset needed: pointers define what is live)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      q_data_q[wr_ptr_q] <= imem_rsp_data;
      q_pc_q[wr_ptr_q]   <= rsp_pc;
    end
    if (accept) begin
      infl_pc_q[infl_wr_q] <= pc_q;
    end
  end

`ifdef FETCH_STATS_EN
  // -------------------------------------------------------------------------
  // Saturating statistics counters
  // -------------------------------------------------------------------------
  logic [31:0] fetched_q;
  logic [31:0] dropped_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetched_q <= 32'd0;
      dropped_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      if (accept && (fetched_q != 32'hFFFF_FFFF)) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (rsp_lost && (dropped_q != 32'hFFFF_FFFF)) begin
        dropped_q <= dropped_q + 32'd1;
      end
      if (!iv_q && !halted_q && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_dropped = dropped_q;
  assign stat_stall   = stall_q;
`else
  logic unused_stats;
  assign unused_stats = &{1'b0, rsp_lost};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A behavioural model (SV queues for the
// prefetch queue and the memory's in-flight requests) predicts every output
// each cycle; a small instruction-memory model answers requests in order
// after a configurable latency. Directed phases pin the model with literal
// expectations, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_dropped;
  logic [31:0] stat_stall;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_dropped   (stat_dropped),
    .stat_stall     (stat_stall)
`endif
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] due; } req_t;
  typedef struct packed { logic [31:0] data; logic [31:0] pc;  } ent_t;

  // Model state
  req_t        pend[$];        // requests accepted by memory, in order
  ent_t        mq[$];          // prefetch queue contents, head first
  logic [31:0] m_pc;
  int          m_drop;
  bit          m_stop;
  bit          m_halted;
  bit          m_started;
  logic [31:0] m_hold_d;
  logic [31:0] m_hold_pc;
  int          m_dropped;
  bit          e_req;

  // Logs for directed checks
  logic [31:0] acc_log[$];
  logic [31:0] hs_pc[$];
  logic [31:0] hs_cyc[$];

  logic [31:0] img [logic [31:0]];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  // Stimulus knobs
  int          ready_pct = 100;
  int          ir_pct    = 100;
  int          lat_min   = 1;
  int          lat_max   = 1;
  bit          redir_req = 0;
  logic [31:0] redir_tgt = 32'd0;
  bit          rst_req   = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (img.exists(a)) return img[a];
    return {a[31:2], 2'b11} ^ 32'h0000_1000; // low bits 11: never zero
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic model_update();
    req_t r;
    ent_t p;
    bit   acc;
    bit   rsp;
    r = '0;
    if (!reset) begin
      mq.delete();
      pend.delete();
      m_pc      = RESET_PC;
      m_drop    = 0;
      m_stop    = 0;
      m_halted  = 0;
      m_started = 0;
      m_hold_d  = 32'd0;
      m_hold_pc = 32'd0;
      return;
    end
    acc = e_req && imem_req_ready;
    rsp = imem_rsp_valid;
    m_started = 1;
    if (rsp) r = pend.pop_front();
    if (acc) begin
      pend.push_back(req_t'{addr: m_pc, due: 32'(cyc + $urandom_range(lat_max, lat_min))});
      acc_log.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (redirect_valid) begin
      mq.delete();
      m_drop   = pend.size();
      m_pc     = {redirect_pc[31:2], 2'b00};
      m_stop   = 0;
      m_halted = 0;
      if (rsp) m_dropped++;
    end else begin
      if (mq.size() > 0 && instr_ready) begin
        p = mq.pop_front();
        hs_pc.push_back(p.pc);
        hs_cyc.push_back(32'(cyc));
        $display("cycle %0d: instr pc=%h data=%h", cyc, p.pc, p.data);
        if (p.data == 32'd0) m_halted = 1;
      end
      if (rsp) begin
        if (m_drop > 0) begin
          m_drop--;
          m_dropped++;
        end else if (m_stop) begin
          m_dropped++;
        end else begin
          mq.push_back(ent_t'{data: imem_rsp_data, pc: r.addr});
          if (imem_rsp_data == 32'd0) m_stop = 1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    reset          = !rst_req;
    redirect_valid = redir_req;
    redirect_pc    = redir_tgt;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    instr_ready    = ($urandom_range(99) < ir_pct);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (!rst_req && pend.size() > 0 && pend[0].due <= 32'(cyc)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(pend[0].addr);
    end
    e_req = reset && m_started && !m_halted && !m_stop && !redirect_valid
            && (mq.size() + pend.size() < DEPTH);
    if (mq.size() > 0) begin
      m_hold_d  = mq[0].data;
      m_hold_pc = mq[0].pc;
    end
    #1;
    if (chk_en) begin
      chk("req_valid", 32'(imem_req_valid), 32'(e_req));
      if (e_req) chk("req_addr", imem_req_addr, m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
      chk("instr", instr, m_hold_d);
      chk("instr_pc", instr_pc, m_hold_pc);
      chk("halted", 32'(halted), 32'(m_halted));
    end
    @(posedge clk);
    model_update();
    cyc++;
    redir_req = 0;
    rst_req   = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_logs();
    acc_log.delete();
    hs_pc.delete();
    hs_cyc.delete();
  endtask

  initial begin
    int dropped_before;
    bit found;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_before;
`endif
    reset = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'd0; instr_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    m_dropped = 0; m_drop = 0; m_stop = 0; m_halted = 0; m_started = 0;
    m_hold_d = 32'd0; m_hold_pc = 32'd0; m_pc = RESET_PC; e_req = 0;

    img[32'h0] = 32'h0050_0093;
    img[32'h4] = 32'h0030_0113;
    img[32'h8] = 32'h0020_81B3;
    img[32'hC] = 32'h0000_0000;

    // Reset state
    rst_req = 1; cycle();
    chk_en = 1;
    rst_req = 1; cycle();
    #2;
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);

    // Straight line: latency 1, decode always ready
    clear_logs();
    run(10);
    chk("sl_count", 32'(hs_pc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("sl_pc", qget(hs_pc, i), 32'(4 * i));
      chk("sl_consecutive", qget(hs_cyc, i), qget(hs_cyc, 0) + 32'(i));
    end
    chk("sl_last_req", qget(acc_log, acc_log.size() - 1), 32'h10);
    #2;
    chk("sl_halted", 32'(halted), 32'd1);

    // Backpressure: decode stalled for 10 cycles after a fresh reset
    rst_req = 1; cycle();
    clear_logs();
    ir_pct = 0;
    run(10);
    chk("bp_accepted", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("bp_req_addr", qget(acc_log, i), 32'(4 * i));
    #2;
    chk("bp_req_idle", 32'(imem_req_valid), 32'd0);
    ir_pct = 100;
    run(8);
    chk("bp_delivered", 32'(hs_pc.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("bp_order", qget(hs_pc, i), 32'(4 * i));
    #2;
    chk("bp_halted", 32'(halted), 32'd1);

    // Redirect after halt
    clear_logs();
    redir_req = 1; redir_tgt = 32'h100; cycle();
    #2;
    chk("rh_halted_clear", 32'(halted), 32'd0);
    run(3);
    chk("rh_first_req", qget(acc_log, 0), 32'h100);

    // Redirect with two requests in flight (latency 3)
    lat_min = 3; lat_max = 3;
    redir_req = 1; redir_tgt = 32'h100; cycle();
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (pend.size() == 2 && m_drop == 0 && pend[0].due > 32'(cyc)) found = 1;
      else cycle();
    end
    chk("if_setup_found", 32'(found), 32'd1);
    dropped_before = m_dropped;
`ifdef FETCH_STATS_EN
    #2;
    stat_before = stat_dropped;
`endif
    clear_logs();
    redir_req = 1; redir_tgt = 32'h40; cycle();
    chk("if_drop_count", 32'(m_drop), 32'd2);
    run(10);
    chk("if_dropped", 32'(m_dropped - dropped_before), 32'd2);
    chk("if_next_pc", qget(hs_pc, 0), 32'h40);
`ifdef FETCH_STATS_EN
    #2;
    chk("if_stat_dropped", stat_dropped - stat_before, 32'd2);
`endif

    // Mid-run reset with three buffered words
    lat_min = 1; lat_max = 1;
    redir_req = 1; redir_tgt = 32'h300; cycle();
    ir_pct = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq.size() == 3) found = 1;
      else cycle();
    end
    chk("mr_setup_found", 32'(found), 32'd1);
    rst_req = 1; cycle();
    #2;
    chk("mr_instr_valid", 32'(instr_valid), 32'd0);
    ir_pct = 100;
    clear_logs();
    run(3);
    chk("mr_first_req", qget(acc_log, 0), RESET_PC);

    // Address wrap (low target bits ignored)
    clear_logs();
    redir_req = 1; redir_tgt = 32'hFFFF_FFFE; cycle();
    run(4);
    chk("wrap_first", qget(acc_log, 0), 32'hFFFF_FFFC);
    chk("wrap_next", qget(acc_log, 1), 32'h0000_0000);

    // Randomized traffic
    lat_min = 1; lat_max = 5;
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 0) begin
        ready_pct = $urandom_range(100, 30);
        ir_pct    = $urandom_range(100, 20);
      end
      if ($urandom_range(999) < 3) begin
        rst_req = 1;
      end else if ($urandom_range(99) < 3) begin
        redir_req = 1;
        redir_tgt = ($urandom_range(1) == 1) ? 32'($urandom_range(63)) : $urandom;
      end
      clear_logs();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
